// File: rtl/cdc_handshake_tx.sv
// Transmit side of a four-phase req/ack CDC handshake: captures a local word,
// raises a level request, and waits on a flop-synchronized acknowledge.
module cdc_handshake_tx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    output logic              xfer_req,
    output logic [DATA_W-1:0] xfer_data,
    input  logic              xfer_ack,
    output logic              done,
    output logic              timeout_err
);

    localparam int               CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam bit               TO_EN    = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  ack_sync;
    logic                    ack_s;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    req_d;
    logic [DATA_W-1:0]       data_d;
    logic                    done_d;
    logic                    err_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    // xfer_ack is asynchronous; only the last synchronizer stage is used.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], xfer_ack};
        end
    end

    assign ack_s = ack_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            xfer_req    <= 1'b0;
            xfer_data   <= '0;
            cnt_q       <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            xfer_req    <= req_d;
            xfer_data   <= data_d;
            cnt_q       <= cnt_d;
            done        <= done_d;
            timeout_err <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_d     = xfer_req;
        data_d    = xfer_data;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        err_d     = timeout_err;
        src_ready = 1'b0;
        case (state_q)
            IDLE: begin
                // A stale ack from the far side blocks new requests until it clears.
                src_ready = !ack_s;
                if (src_valid && !ack_s) begin
                    data_d  = src_data;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = DROP;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                    if (TO_EN && cnt_q == CNT_LAST) begin
                        err_d = 1'b1;
                    end
                end
            end
            DROP: begin
                if (!ack_s) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Bench for cdc_handshake_tx: cycle-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_cdc_handshake_tx;

    localparam int DW = 8;
    localparam int SS = 2;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          src_valid;
    logic [DW-1:0] src_data;
    logic          src_ready;
    logic          xfer_req;
    logic [DW-1:0] xfer_data;
    logic          xfer_ack;
    logic          done;
    logic          timeout_err;

    logic echo = 1'b0;
    logic ack_man = 1'b0;

    assign xfer_ack = echo ? xfer_req : ack_man;

    always #5 clk = ~clk;

    cdc_handshake_tx #(
        .DATA_W     (DW),
        .SYNC_STAGES(SS),
        .TIMEOUT    (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .src_ready  (src_ready),
        .xfer_req   (xfer_req),
        .xfer_data  (xfer_data),
        .xfer_ack   (xfer_ack),
        .done       (done),
        .timeout_err(timeout_err)
    );

    int nchk  = 0;
    int nfail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: protocol phase, sampled-ack log, and the words handed over.
    localparam int P_IDLE = 0;
    localparam int P_REQ  = 1;
    localparam int P_DROP = 2;

    int            cyc = 0;
    int            rst_cyc = 0;
    bit            ack_log[$] = '{1'b0};
    int            m_phase = P_IDLE;
    bit            m_req = 1'b0;
    logic [DW-1:0] m_data = '0;
    bit            m_done = 1'b0;
    bit            m_err = 1'b0;
    int            m_wait = 0;

    // The synchronized ack after edge c is the raw ack sampled SS-1 edges earlier,
    // unless a reset within the last SS edges has flushed it.
    function automatic bit ack_s_at(input int c);
        if (c - rst_cyc >= SS) return ack_log[c - SS + 1];
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        bit as;
        as = ack_s_at(cyc);
        cyc++;
        ack_log.push_back(xfer_ack);
        if (rst) begin
            rst_cyc = cyc;
            m_phase = P_IDLE;
            m_req   = 1'b0;
            m_data  = '0;
            m_done  = 1'b0;
            m_err   = 1'b0;
            m_wait  = 0;
        end else begin
            m_done = 1'b0;
            if (m_phase == P_IDLE) begin
                if (src_valid && !as) begin
                    m_data  = src_data;
                    m_req   = 1'b1;
                    m_wait  = 0;
                    m_phase = P_REQ;
                end
            end else if (m_phase == P_REQ) begin
                if (as) begin
                    m_req   = 1'b0;
                    m_phase = P_DROP;
                end else begin
                    m_wait++;
                    if (TO != 0 && m_wait == TO) m_err = 1'b1;
                end
            end else begin
                if (!as) begin
                    m_phase = P_IDLE;
                    m_done  = 1'b1;
                end
            end
        end
    end

    logic [DW-1:0] seen[$];
    bit            collect = 1'b0;

    always @(negedge clk) begin
        check("src_ready", 32'(src_ready), 32'((m_phase == P_IDLE) && !ack_s_at(cyc)));
        check("xfer_req", 32'(xfer_req), 32'(m_req));
        check("xfer_data", 32'(xfer_data), 32'(m_data));
        check("done", 32'(done), 32'(m_done));
        check("timeout_err", 32'(timeout_err), 32'(m_err));
        if (collect && done) seen.push_back(xfer_data);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected end of test");
        nfail++;
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    initial begin
        int            reqcnt;
        int            donei;
        int            n;
        int            k;
        bit            pend;
        bit            dseen;
        logic [DW-1:0] words[3];

        rst = 1'b1;
        src_valid = 1'b0;
        src_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_src_ready", 32'(src_ready), 32'(1));
        check("rst_xfer_req", 32'(xfer_req), 32'(0));
        check("rst_xfer_data", 32'(xfer_data), 32'h00);
        check("rst_timeout_err", 32'(timeout_err), 32'(0));
        @(negedge clk);
        check("idle_src_ready", 32'(src_ready), 32'(1));

        // Single word against a zero-delay echo responder.
        echo = 1'b1;
        src_data = 8'hA5;
        src_valid = 1'b1;
        @(negedge clk);
        src_valid = 1'b0;
        reqcnt = int'(xfer_req);
        donei = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            reqcnt += int'(xfer_req);
            if (done && donei < 0) donei = i;
        end
        check("a5_req_cycles", 32'(reqcnt), 32'(3));
        check("a5_done_latency", 32'(donei), 32'(6));
        check("a5_data", 32'(xfer_data), 32'hA5);

        // Three words offered back to back with src_valid held.
        words[0] = 8'h01;
        words[1] = 8'h02;
        words[2] = 8'h03;
        seen.delete();
        collect = 1'b1;
        k = 0;
        src_data = words[0];
        src_valid = 1'b1;
        pend = src_ready;
        for (int c = 0; c < 80 && k < 3; c++) begin
            @(negedge clk);
            if (pend) begin
                k++;
                if (k < 3) src_data = words[k];
                else src_valid = 1'b0;
            end
            pend = (k < 3) && src_ready;
        end
        src_valid = 1'b0;
        repeat (12) @(negedge clk);
        collect = 1'b0;
        check("seq_accepted", 32'(k), 32'(3));
        check("seq_done_count", 32'(seen.size()), 32'(3));
        for (int i = 0; i < 3; i++) begin
            if (i < seen.size()) check("seq_word_order", 32'(seen[i]), 32'(words[i]));
        end

        // Stale ack while idle blocks acceptance.
        echo = 1'b0;
        ack_man = 1'b1;
        repeat (3) @(negedge clk);
        check("stale_src_ready", 32'(src_ready), 32'(0));
        src_data = 8'h55;
        src_valid = 1'b1;
        repeat (4) @(negedge clk);
        check("stale_no_req", 32'(xfer_req), 32'(0));
        check("stale_data_kept", 32'(xfer_data), 32'h03);
        src_valid = 1'b0;
        ack_man = 1'b0;
        n = 0;
        while (!src_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("stale_release_edges", 32'(n), 32'(SS));

        // Timeout with no ack, then late completion.
        src_data = 8'hC3;
        src_valid = 1'b1;
        @(negedge clk);
        src_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 7) check("to_err_before", 32'(timeout_err), 32'(0));
            if (i == 8) begin
                check("to_err_set", 32'(timeout_err), 32'(1));
                check("to_req_held", 32'(xfer_req), 32'(1));
            end
        end
        repeat (3) @(negedge clk);
        check("to_req_still", 32'(xfer_req), 32'(1));
        ack_man = 1'b1;
        n = 0;
        while (xfer_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("to_req_drop_in_bound", 32'(n < 20), 32'(1));
        ack_man = 1'b0;
        dseen = 1'b0;
        n = 0;
        while (!dseen && n < 20) begin
            @(negedge clk);
            n++;
            if (done) dseen = 1'b1;
        end
        check("to_done_seen", 32'(dseen), 32'(1));
        check("to_err_sticky", 32'(timeout_err), 32'(1));
        check("to_data", 32'(xfer_data), 32'hC3);

        // Reset while in REQ aborts the transfer.
        @(negedge clk);
        src_data = 8'h3C;
        src_valid = 1'b1;
        @(negedge clk);
        src_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_req_before", 32'(xfer_req), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_req", 32'(xfer_req), 32'(0));
        check("abort_data", 32'(xfer_data), 32'h00);
        check("abort_err", 32'(timeout_err), 32'(0));
        check("abort_idle", 32'(src_ready), 32'(1));
        dseen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) dseen = 1'b1;
        end
        check("abort_no_done", 32'(dseen), 32'(0));

        // Randomized traffic with a slow random responder and rare resets.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            src_valid = $urandom_range(0, 1) == 1;
            src_data = 8'($urandom);
            if (ack_man != xfer_req && $urandom_range(0, 2) == 0) ack_man = xfer_req;
        end
        rst = 1'b0;
        src_valid = 1'b0;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
